// File: rtl/aes_pkg.sv
// AES shared helpers: GF(2^8) multiplies, byte indexing,
// InvShiftRows and InvMixColumns on column-major 128-bit states.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_NB      = 4;

   typedef struct packed {
      logic                   valid;
      logic                   last;
      logic [AES_BLOCK_W-1:0] key;
   } s1_t;

   function automatic int byte_idx(input int row, input int col);
      return row + AES_NB * col;
   endfunction

   function automatic logic [7:0] get_byte(
      input logic [AES_BLOCK_W-1:0] s,
      input int                     i
   );
      return s[AES_BLOCK_W-1-8*i -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul9(input logic [7:0] b);
      logic [7:0] x8;
      x8 = xtime(xtime(xtime(b)));
      return x8 ^ b;
   endfunction

   function automatic logic [7:0] gmul11(input logic [7:0] b);
      logic [7:0] x2, x8;
      x2 = xtime(b);
      x8 = xtime(xtime(x2));
      return x8 ^ x2 ^ b;
   endfunction

   function automatic logic [7:0] gmul13(input logic [7:0] b);
      logic [7:0] x4, x8;
      x4 = xtime(xtime(b));
      x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic logic [7:0] gmul14(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

   // Row r rotates right by r columns.
   function automatic logic [AES_BLOCK_W-1:0] inv_shift_rows(
      input logic [AES_BLOCK_W-1:0] s
   );
      logic [AES_BLOCK_W-1:0] o;
      o = '0;
      for (int c = 0; c < AES_NB; c++) begin
         for (int r = 0; r < AES_NB; r++) begin
            o[AES_BLOCK_W-1-8*byte_idx(r, c) -: 8] =
               get_byte(s, byte_idx(r, (c - r + AES_NB) % AES_NB));
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      b0 = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
      b1 = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
      b2 = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
      b3 = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
      return {b0, b1, b2, b3};
   endfunction

   function automatic logic [AES_BLOCK_W-1:0] inv_mix_columns(
      input logic [AES_BLOCK_W-1:0] s
   );
      logic [AES_BLOCK_W-1:0] o;
      o = '0;
      for (int c = 0; c < AES_NB; c++) begin
         o[AES_BLOCK_W-1-32*c -: 32] =
            inv_mix_column(s[AES_BLOCK_W-1-32*c -: 32]);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, 256x8 ROM with registered read.
// Ports: clk, en (read enable), addr[7:0], data[7:0] (one cycle after addr).
module aes_inv_sbox (
   input  logic       clk,
   input  logic       en,
   input  logic [7:0] addr,
   output logic [7:0] data
);

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   always_ff @(posedge clk) begin
      if (en) data <= INV_SBOX[addr];
   end

endmodule

// File: rtl/decrypt_single_round.sv
// One AES inverse-cipher round as a 2-stage valid/ready pipeline.
// Ports: clk, rst (sync, active-high); round_valid_in/round_ready_out,
// state_in, key_in, last_round_in in; state_out, round_valid_out/round_ready_in out.
module decrypt_single_round
   import aes_pkg::*;
#(
   parameter int DATA_WIDTH = AES_BLOCK_W,
   parameter int KEY_WIDTH  = AES_BLOCK_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  round_valid_in,
   output logic                  round_ready_out,
   input  logic [DATA_WIDTH-1:0] state_in,
   input  logic [KEY_WIDTH-1:0]  key_in,
   input  logic                  last_round_in,
   output logic [DATA_WIDTH-1:0] state_out,
   output logic                  round_valid_out,
   input  logic                  round_ready_in
);

   logic                  en;
   logic [DATA_WIDTH-1:0] sr;
   logic [DATA_WIDTH-1:0] sb;
   s1_t                   s1;
   logic                  s1_clr;
   logic [DATA_WIDTH-1:0] s1_state;
   logic [DATA_WIDTH-1:0] t;
   logic [DATA_WIDTH-1:0] mixed;

   // Whole pipe advances together; stalls only on held output.
   assign en              = ~round_valid_out | round_ready_in;
   assign round_ready_out = en;

   assign sr = inv_shift_rows(state_in);

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_inv_sbox u_sbox (
         .clk  (clk),
         .en   (en),
         .addr (sr[DATA_WIDTH-1-8*i -: 8]),
         .data (sb[DATA_WIDTH-1-8*i -: 8])
      );
   end

   // The S-box ROMs carry no reset; mask their output after reset.
   assign s1_state = s1_clr ? '0 : sb;
   assign t        = s1_state ^ s1.key;
   assign mixed    = inv_mix_columns(t);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1              <= '0;
         s1_clr          <= 1'b1;
         state_out       <= '0;
         round_valid_out <= 1'b0;
      end else if (en) begin
         s1.valid        <= round_valid_in;
         s1.last         <= last_round_in;
         s1.key          <= key_in;
         s1_clr          <= 1'b0;
         round_valid_out <= s1.valid;
         state_out       <= s1.last ? t : mixed;
      end
   end

endmodule

// File: tb/tb_decrypt_single_round.sv
// Directed and scoreboarded bench for decrypt_single_round.
// Uses an arithmetic GF(2^8) model independent of the RTL tables.
module tb_decrypt_single_round;

   logic         clk = 1'b0;
   logic         rst;
   logic         round_valid_in;
   logic         round_ready_out;
   logic [127:0] state_in;
   logic [127:0] key_in;
   logic         last_round_in;
   logic [127:0] state_out;
   logic         round_valid_out;
   logic         round_ready_in;

   int vec_count = 0;
   int err_count = 0;

   logic [7:0] inv_tab [256];

   localparam logic [127:0] FIN_IN  = 128'h6353e08c0960e104cd70b751bacad0e7;
   localparam logic [127:0] FIN_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIN_OUT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] MID_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
   localparam logic [127:0] MID_KEY = 128'h549932d1f08557681093ed9cbe2c974e;
   localparam logic [127:0] MID_OUT = 128'h54d990a16ba09ab596bbf40ea111702f;
   localparam logic [7:0]   AFF_C   = 8'h05;

   always #5 clk = ~clk;

   decrypt_single_round dut (
      .clk             (clk),
      .rst             (rst),
      .round_valid_in  (round_valid_in),
      .round_ready_out (round_ready_out),
      .state_in        (state_in),
      .key_in          (key_in),
      .last_round_in   (last_round_in),
      .state_out       (state_out),
      .round_valid_out (round_valid_out),
      .round_ready_in  (round_ready_in)
   );

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // inv_sbox(x) = inverse(inverse_affine(x)), inverse via x^254.
   task automatic init_model();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] v;
         logic [7:0] a;
         logic [7:0] r;
         v = 8'(x);
         for (int i = 0; i < 8; i++)
            a[i] = v[(i+2)%8] ^ v[(i+5)%8] ^ v[(i+7)%8] ^ AFF_C[i];
         r = 8'h00;
         if (a != 8'h00) begin
            r = 8'h01;
            for (int j = 0; j < 254; j++) r = gm(r, a);
         end
         inv_tab[x] = r;
      end
   endtask

   function automatic logic [127:0] model_round(
      input logic [127:0] s,
      input logic [127:0] k,
      input logic         l
   );
      logic [7:0]   in_b [16];
      logic [7:0]   isr  [16];
      logic [7:0]   t    [16];
      logic [7:0]   o    [16];
      logic [7:0]   coef [4];
      logic [127:0] res;
      coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      res  = '0;
      for (int i = 0; i < 16; i++) in_b[i] = s[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            isr[r + 4*((c + r) % 4)] = in_b[r + 4*c];
      for (int i = 0; i < 16; i++) t[i] = inv_tab[isr[i]] ^ k[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[r + 4*c] = 8'h00;
            for (int q = 0; q < 4; q++)
               o[r + 4*c] = o[r + 4*c] ^ gm(coef[(q - r + 4) % 4], t[q + 4*c]);
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = l ? t[i] : o[i];
      return res;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [127:0] s, input logic [127:0] k, input logic l);
      round_valid_in = 1'b1;
      state_in       = s;
      key_in         = k;
      last_round_in  = l;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      round_valid_in = 1'b0;
      round_ready_in = 1'b1;
      state_in       = '0;
      key_in         = '0;
      last_round_in  = 1'b0;
      step();
      step();
      vec_count++;
      if (round_valid_out !== 1'b0) begin
         err_count++;
         $display("FAIL reset_valid got=%b exp=0", round_valid_out);
      end
      vec_count++;
      if (state_out !== 128'h0) begin
         err_count++;
         $display("FAIL reset_state got=%h exp=0", state_out);
      end
      rst = 1'b0;
      round_ready_in = 1'b0;
      #1;
      vec_count++;
      if (round_ready_out !== 1'b1) begin
         err_count++;
         $display("FAIL reset_ready got=%b exp=1", round_ready_out);
      end
      round_ready_in = 1'b1;
   endtask

   task automatic test_single(
      input string        name,
      input logic [127:0] s,
      input logic [127:0] k,
      input logic         l,
      input logic [127:0] exp
   );
      drive(s, k, l);
      step();
      round_valid_in = 1'b0;
      vec_count++;
      if (round_valid_out !== 1'b0) begin
         err_count++;
         $display("FAIL %s_early_valid got=%b exp=0", name, round_valid_out);
      end
      step();
      vec_count++;
      if (round_valid_out !== 1'b1 || state_out !== exp) begin
         err_count++;
         $display("FAIL %s_result got=%b/%h exp=1/%h", name, round_valid_out, state_out, exp);
      end
      step();
      vec_count++;
      if (round_valid_out !== 1'b0) begin
         err_count++;
         $display("FAIL %s_drain got=%b exp=0", name, round_valid_out);
      end
   endtask

   task automatic test_final_round();
      test_single("final", FIN_IN, FIN_KEY, 1'b1, FIN_OUT);
   endtask

   task automatic test_middle_round();
      test_single("middle", MID_IN, MID_KEY, 1'b0, MID_OUT);
   endtask

   task automatic test_back_to_back();
      drive(FIN_IN, FIN_KEY, 1'b1);
      step();
      drive(MID_IN, MID_KEY, 1'b0);
      step();
      round_valid_in = 1'b0;
      vec_count++;
      if (round_valid_out !== 1'b1 || state_out !== FIN_OUT) begin
         err_count++;
         $display("FAIL stream_first got=%b/%h exp=1/%h", round_valid_out, state_out, FIN_OUT);
      end
      step();
      vec_count++;
      if (round_valid_out !== 1'b1 || state_out !== MID_OUT) begin
         err_count++;
         $display("FAIL stream_second got=%b/%h exp=1/%h", round_valid_out, state_out, MID_OUT);
      end
      step();
      vec_count++;
      if (round_valid_out !== 1'b0) begin
         err_count++;
         $display("FAIL stream_drain got=%b exp=0", round_valid_out);
      end
   endtask

   task automatic test_backpressure();
      drive(FIN_IN, FIN_KEY, 1'b1);
      step();
      drive(MID_IN, MID_KEY, 1'b0);
      step();
      // Third item is presented during the stall and must wait.
      drive(FIN_IN, FIN_KEY, 1'b1);
      round_ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         vec_count++;
         if (round_ready_out !== 1'b0) begin
            err_count++;
            $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, round_ready_out);
         end
         vec_count++;
         if (round_valid_out !== 1'b1 || state_out !== FIN_OUT) begin
            err_count++;
            $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", i, round_valid_out, state_out, FIN_OUT);
         end
         step();
      end
      round_ready_in = 1'b1;
      #1;
      vec_count++;
      if (round_ready_out !== 1'b1 || state_out !== FIN_OUT) begin
         err_count++;
         $display("FAIL release_ready got=%b/%h exp=1/%h", round_ready_out, state_out, FIN_OUT);
      end
      step();
      round_valid_in = 1'b0;
      vec_count++;
      if (round_valid_out !== 1'b1 || state_out !== MID_OUT) begin
         err_count++;
         $display("FAIL release_second got=%b/%h exp=1/%h", round_valid_out, state_out, MID_OUT);
      end
      step();
      vec_count++;
      if (round_valid_out !== 1'b1 || state_out !== FIN_OUT) begin
         err_count++;
         $display("FAIL release_third got=%b/%h exp=1/%h", round_valid_out, state_out, FIN_OUT);
      end
      step();
      vec_count++;
      if (round_valid_out !== 1'b0) begin
         err_count++;
         $display("FAIL release_drain got=%b exp=0", round_valid_out);
      end
   endtask

   task automatic test_reset_midstream();
      drive(FIN_IN, FIN_KEY, 1'b1);
      step();
      drive(MID_IN, MID_KEY, 1'b0);
      step();
      round_valid_in = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      vec_count++;
      if (round_valid_out !== 1'b0 || state_out !== 128'h0) begin
         err_count++;
         $display("FAIL midrst_clear got=%b/%h exp=0/0", round_valid_out, state_out);
      end
      vec_count++;
      if (round_ready_out !== 1'b1) begin
         err_count++;
         $display("FAIL midrst_ready got=%b exp=1", round_ready_out);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         vec_count++;
         if (round_valid_out !== 1'b0) begin
            err_count++;
            $display("FAIL midrst_ghost cyc=%0d got=%b exp=0", i, round_valid_out);
         end
      end
   endtask

   task automatic test_random();
      logic [127:0] exp_q [$];
      logic [127:0] e;
      int           sent;
      int           got;
      int           cycles;
      logic         in_fire;
      logic         out_fire;
      sent   = 0;
      got    = 0;
      cycles = 0;
      round_valid_in = 1'b0;
      while (got < 1000 && cycles < 20000) begin
         if (!round_valid_in) begin
            state_in      = {$urandom, $urandom, $urandom, $urandom};
            key_in        = {$urandom, $urandom, $urandom, $urandom};
            last_round_in = 1'($urandom_range(0, 1));
            if (sent < 1000 && $urandom_range(0, 3) != 0) round_valid_in = 1'b1;
         end
         round_ready_in = ($urandom_range(0, 3) != 0);
         #1;
         out_fire = round_valid_out & round_ready_in;
         in_fire  = round_valid_in & round_ready_out;
         if (out_fire) begin
            got++;
            vec_count++;
            if (exp_q.size() == 0) begin
               err_count++;
               $display("FAIL rand_extra got=%h exp=none", state_out);
            end else begin
               e = exp_q.pop_front();
               if (state_out !== e) begin
                  err_count++;
                  $display("FAIL rand_item n=%0d got=%h exp=%h", got, state_out, e);
               end
            end
         end
         if (in_fire) begin
            exp_q.push_back(model_round(state_in, key_in, last_round_in));
            sent++;
         end
         step();
         cycles++;
         if (in_fire) round_valid_in = 1'b0;
      end
      vec_count++;
      if (got != 1000 || exp_q.size() != 0) begin
         err_count++;
         $display("FAIL rand_count got=%0d left=%0d exp=1000/0", got, exp_q.size());
      end
      round_valid_in = 1'b0;
      round_ready_in = 1'b1;
   endtask

   initial begin
      init_model();
      test_reset();
      test_final_round();
      test_middle_round();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
